// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and helpers for the 1R1W pipelined memory
package mem_pkg;

    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A single-word memory still needs a one-bit address port.
    function automatic int addr_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/mem_lat_pipe.sv
// rtl/mem_lat_pipe.sv - fixed-length valid/data delay line, data held while invalid
module mem_lat_pipe #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (STAGES < 1) begin : g_bad_stages
        $error("mem_lat_pipe: STAGES must be at least 1");
    end

    logic [STAGES-1:0] valid_q;
    logic [WIDTH-1:0]  data_q [STAGES];

    // Data registers only load behind a valid bit, so the last result stays put.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                data_q[0] <= in_data;
            end
            for (int i = 1; i < STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];

endmodule

// File: rtl/mem_1r1w_pipe.sv
// rtl/mem_1r1w_pipe.sv - one-read one-write masked memory with pipelined read return
module mem_1r1w_pipe
    import mem_pkg::*;
#(
    parameter int WIDTH        = 64,
    parameter int DEPTH        = 48,
    parameter int MASK_GRAN    = 8,
    parameter int READ_LATENCY = 1,
    localparam int MW          = WIDTH / MASK_GRAN,
    localparam int AW          = addr_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW-1:0]    R0_addr,
    input  logic             R0_en,
    output logic [WIDTH-1:0] R0_data,
    output logic             R0_valid,
    input  logic [AW-1:0]    W0_addr,
    input  logic             W0_en,
    input  logic [WIDTH-1:0] W0_data,
    input  logic [MW-1:0]    W0_mask
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("mem_1r1w_pipe: DEPTH must be at least 1");
    end
    if (WIDTH % MASK_GRAN != 0) begin : g_bad_mask
        $error("mem_1r1w_pipe: WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_lat
        $error("mem_1r1w_pipe: READ_LATENCY out of range");
    end

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             rd_in_range;
    logic             wr_in_range;
    logic             rd_fire;
    logic             wr_fire;
    logic [WIDTH-1:0] lane_bits;
    logic [WIDTH-1:0] rd_word;

    assign rd_in_range = {1'b0, R0_addr} < DEPTH_W;
    assign wr_in_range = {1'b0, W0_addr} < DEPTH_W;
    assign rd_fire     = R0_en & ~reset;
    assign wr_fire     = W0_en & ~reset & wr_in_range;

    always_comb begin
        lane_bits = '0;
        for (int i = 0; i < MW; i++) begin
            lane_bits[i*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{W0_mask[i]}};
        end
    end

    // Read word is captured at issue; a colliding write is forwarded lane by lane.
    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[R0_addr];
            if (wr_fire && (W0_addr == R0_addr)) begin
                rd_word = (rd_word & ~lane_bits) | (W0_data & lane_bits);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            for (int i = 0; i < MW; i++) begin
                if (W0_mask[i]) begin
                    mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    mem_lat_pipe #(
        .WIDTH  (WIDTH),
        .STAGES (READ_LATENCY)
    ) u_lat_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (rd_fire),
        .in_data   (rd_word),
        .out_valid (R0_valid),
        .out_data  (R0_data)
    );

endmodule

// File: tb/tb_mem_1r1w_pipe.sv
// tb/tb_mem_1r1w_pipe.sv - scoreboard bench over three memory configurations
module tb_mem_1r1w_pipe;

    typedef struct {
        int          dut;
        int          due;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        int          dut;
        int          cyc;
        logic [63:0] data;
    } rec_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issue_cyc = 0;
    bit mon_on = 0;

    int rl_of[3]  = '{1, 3, 2};
    int dep_of[3] = '{48, 48, 16};

    exp_t        sb[$];
    rec_t        lg[$];
    logic [63:0] mm[3][64];
    logic [63:0] last[3];

    logic        clock = 0;
    logic        reset = 1;
    logic [5:0]  raddr[3];
    logic [5:0]  waddr[3];
    logic        ren[3];
    logic        wen[3];
    logic [63:0] wdata[3];
    logic [7:0]  wmask[3];
    logic [63:0] rd0, rd1;
    logic [31:0] rd2;
    logic        vld[3];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_1r1w_pipe u_d0 (
        .clock(clock), .reset(reset),
        .R0_addr(raddr[0]), .R0_en(ren[0]), .R0_data(rd0), .R0_valid(vld[0]),
        .W0_addr(waddr[0]), .W0_en(wen[0]), .W0_data(wdata[0]), .W0_mask(wmask[0])
    );

    mem_1r1w_pipe #(.READ_LATENCY(3)) u_d1 (
        .clock(clock), .reset(reset),
        .R0_addr(raddr[1]), .R0_en(ren[1]), .R0_data(rd1), .R0_valid(vld[1]),
        .W0_addr(waddr[1]), .W0_en(wen[1]), .W0_data(wdata[1]), .W0_mask(wmask[1])
    );

    mem_1r1w_pipe #(.WIDTH(32), .MASK_GRAN(8), .DEPTH(16), .READ_LATENCY(2)) u_d2 (
        .clock(clock), .reset(reset),
        .R0_addr(raddr[2][3:0]), .R0_en(ren[2]), .R0_data(rd2), .R0_valid(vld[2]),
        .W0_addr(waddr[2][3:0]), .W0_en(wen[2]), .W0_data(wdata[2][31:0]), .W0_mask(wmask[2][3:0])
    );

    function automatic logic [63:0] rdata_of(input int d);
        case (d)
            0:       return rd0;
            1:       return rd1;
            default: return {32'b0, rd2};
        endcase
    endfunction

    function automatic logic [63:0] width_mask(input int d);
        return (d == 2) ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    endfunction

    function automatic logic [63:0] lane_mask(input int d, input logic [7:0] m);
        logic [63:0] lm;
        for (int b = 0; b < 64; b++) lm[b] = m[b / 8];
        return lm & width_mask(d);
    endfunction

    // Reference model: one clock edge applied to every configuration.
    task automatic step();
        logic [63:0] e, lm;
        @(negedge clock);
        #1;
        issue_cyc = cyc;
        if (reset) begin
            sb.delete();
            for (int d = 0; d < 3; d++) last[d] = '0;
        end else begin
            for (int d = 0; d < 3; d++) begin
                lm = lane_mask(d, wmask[d]);
                if (ren[d]) begin
                    e = (int'(raddr[d]) >= dep_of[d]) ? 64'd0 : mm[d][raddr[d]];
                    if (wen[d] && waddr[d] == raddr[d] && int'(waddr[d]) < dep_of[d])
                        e = (e & ~lm) | (wdata[d] & lm);
                    sb.push_back('{dut: d, due: cyc + rl_of[d], data: e & width_mask(d)});
                end
                if (wen[d] && int'(waddr[d]) < dep_of[d])
                    mm[d][waddr[d]] = (mm[d][waddr[d]] & ~lm) | (wdata[d] & lm);
            end
        end
        @(posedge clock);
        #1;
        for (int d = 0; d < 3; d++) begin
            ren[d] = 0;
            wen[d] = 0;
        end
    endtask

    task automatic do_write(input int d, input int a, input logic [63:0] v, input logic [7:0] m);
        waddr[d] = 6'(a);
        wdata[d] = v;
        wmask[d] = m;
        wen[d]   = 1;
    endtask

    task automatic do_read(input int d, input int a);
        raddr[d] = 6'(a);
        ren[d]   = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_log(input int d, input int at, input logic [63:0] want, input string name);
        bit          found;
        logic [63:0] got;
        found = 0;
        got   = 'x;
        foreach (lg[i]) begin
            if (lg[i].dut == d && lg[i].cyc == at) begin
                found = 1;
                got   = lg[i].data;
            end
        end
        checks++;
        if (!found || got !== want) begin
            errors++;
            $display("FAIL %s: got %h (returned=%0d) at cycle %0d, want %h", name, got, found, at, want);
        end
    endtask

    task automatic check_no_log(input int d, input int from, input int to, input string name);
        int hits;
        hits = 0;
        foreach (lg[i]) begin
            if (lg[i].dut == d && lg[i].cyc >= from && lg[i].cyc <= to) hits++;
        end
        checks++;
        if (hits != 0) begin
            errors++;
            $display("FAIL %s: %0d results returned, want 0", name, hits);
        end
    endtask

    // Monitor: pops the oldest expectation for each instance as results appear.
    always @(negedge clock) begin
        if (mon_on) begin
            for (int d = 0; d < 3; d++) begin
                int          idx;
                logic [63:0] r;
                idx = -1;
                r   = rdata_of(d);
                for (int i = 0; i < sb.size(); i++) begin
                    if (idx < 0 && sb[i].dut == d) idx = i;
                end
                checks++;
                if (vld[d]) begin
                    lg.push_back('{dut: d, cyc: cyc, data: r});
                    if (idx < 0) begin
                        errors++;
                        $display("FAIL unexpected_valid d%0d: data %h at cycle %0d, want no result", d, r, cyc);
                    end else begin
                        if (r !== sb[idx].data || sb[idx].due != cyc) begin
                            errors++;
                            $display("FAIL read_data d%0d: got %h at cycle %0d, want %h at cycle %0d",
                                     d, r, cyc, sb[idx].data, sb[idx].due);
                        end
                        last[d] = sb[idx].data;
                        sb.delete(idx);
                    end
                end else begin
                    if (r !== last[d]) begin
                        errors++;
                        $display("FAIL hold_data d%0d: got %h at cycle %0d, want %h", d, r, cyc, last[d]);
                    end
                    if (idx >= 0 && sb[idx].due <= cyc) begin
                        checks++;
                        errors++;
                        $display("FAIL missing_valid d%0d: valid 0 at cycle %0d, want %h due at %0d",
                                 d, cyc, sb[idx].data, sb[idx].due);
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c;
        logic [63:0] v;
        for (int d = 0; d < 3; d++) begin
            raddr[d] = '0; waddr[d] = '0; ren[d] = 0; wen[d] = 0;
            wdata[d] = '0; wmask[d] = '0; last[d] = '0;
        end
        reset = 1;
        idle(2);
        mon_on = 1;
        idle(1);
        reset = 0;

        // Default configuration: full write then read-back
        do_write(0, 5, 64'h0123_4567_89AB_CDEF, 8'hFF);
        step();
        do_read(0, 5);
        step();
        c = issue_cyc;
        idle(2);
        check_log(0, c + 1, 64'h0123_4567_89AB_CDEF, "basic_readback");

        // Same-cycle masked write and read: write-first on masked lanes only
        do_write(0, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F);
        do_read(0, 5);
        step();
        c = issue_cyc;
        idle(2);
        check_log(0, c + 1, 64'h0123_4567_FFFF_FFFF, "bypass_partial_mask");

        // Out-of-range write and read
        do_write(0, 2, 64'h2222_3333_4444_5555, 8'hFF);
        step();
        do_write(0, 50, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        step();
        do_read(0, 50);
        step();
        c = issue_cyc;
        do_read(0, 2);
        step();
        idle(2);
        check_log(0, c + 1, 64'd0, "oor_read_zero");
        check_log(0, c + 2, 64'h2222_3333_4444_5555, "oor_write_ignored");

        // Latency 3 back-to-back reads; a later write leaves in-flight data alone
        do_write(1, 0, 64'h10, 8'hFF); step();
        do_write(1, 1, 64'h11, 8'hFF); step();
        do_write(1, 2, 64'h12, 8'hFF); step();
        do_read(1, 0);
        step();
        c = issue_cyc;
        do_read(1, 1);
        step();
        do_read(1, 2);
        do_write(1, 1, 64'h99, 8'hFF);
        step();
        idle(4);
        check_no_log(1, c + 1, c + 2, "lat3_no_early_valid");
        check_log(1, c + 3, 64'h10, "lat3_first");
        check_log(1, c + 4, 64'h11, "lat3_second_unaltered");
        check_log(1, c + 5, 64'h12, "lat3_third");
        do_read(1, 1);
        step();
        c = issue_cyc;
        idle(4);
        check_log(1, c + 3, 64'h99, "lat3_late_write_landed");

        // Latency 2: reset discards the in-flight read, storage survives
        do_write(2, 7, 64'hCAFE_F00D, 8'h0F);
        step();
        do_read(2, 7);
        step();
        c = issue_cyc;
        reset = 1;
        do_write(2, 7, 64'h1111_1111, 8'h0F);
        step();
        reset = 0;
        checks++;
        if (rd2 !== 32'd0 || vld[2] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: data %h valid %b, want 0 and 0", rd2, vld[2]);
        end
        idle(4);
        check_no_log(2, c + 1, c + 5, "reset_discards_inflight");
        do_read(2, 7);
        step();
        c = issue_cyc;
        idle(3);
        check_log(2, c + 2, 64'hCAFE_F00D, "storage_survives_reset");

        // Initialise storage, then random mixed traffic on two configurations
        for (int a = 0; a < 48; a++) begin
            do_write(0, a, {$urandom, $urandom}, 8'hFF);
            if (a < 16) do_write(2, a, {32'b0, $urandom}, 8'h0F);
            step();
        end
        for (int i = 0; i < 1000; i++) begin
            v = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) do_read(0, $urandom_range(0, 63));
            if ($urandom_range(0, 1) != 0) begin
                do_write(0, ($urandom_range(0, 3) == 0) ? int'(raddr[0]) : $urandom_range(0, 63),
                         v, 8'($urandom));
            end
            if ($urandom_range(0, 3) != 0) do_read(2, $urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0) begin
                do_write(2, ($urandom_range(0, 2) == 0) ? int'(raddr[2]) : $urandom_range(0, 15),
                         {32'b0, v[31:0]}, {4'b0, 4'($urandom)});
            end
            step();
        end
        idle(8);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected results never returned, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
